// File: rtl/cpu_flag_unit_if.sv
// Signal bundle between the ALU/branch logic and the status-flag unit.
// The flag unit takes the slave side; the driving logic (or bench) takes the master side.
interface cpu_flag_unit_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_ovf;
    logic             flag_we;
    logic [3:0]       flag_mask;
    logic             push;
    logic             pop;
    logic             err_clr;
    logic [2:0]       cond;
    logic [3:0]       flags;
    logic             n_zero;
    logic             take;
    logic             stack_full;
    logic             stack_empty;
    logic             stack_err;

    modport slave (
        input  alu_result, alu_carry, alu_ovf, flag_we, flag_mask,
        input  push, pop, err_clr, cond,
        output flags, n_zero, take, stack_full, stack_empty, stack_err
    );

    modport master (
        output alu_result, alu_carry, alu_ovf, flag_we, flag_mask,
        output push, pop, err_clr, cond,
        input  flags, n_zero, take, stack_full, stack_empty, stack_err
    );
endinterface

// File: rtl/cpu_flag_unit.sv
// Status-flag register {N,Z,C,V} with branch-condition evaluator and a LIFO
// save/restore stack for interrupt entry and return.
module cpu_flag_unit #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned STACK_DEPTH = 4
) (
    input logic           clk,
    input logic           rst,
    cpu_flag_unit_if.slave bus
);
    localparam int unsigned IW = $clog2(STACK_DEPTH);
    localparam int unsigned PW = IW + 1;
    localparam logic [PW-1:0] FULL_CNT = PW'(STACK_DEPTH);

    logic [3:0]    r_flags;
    logic          r_n_zero;
    logic          r_err;
    logic [PW-1:0] r_sp;
    logic [3:0]    r_stack [STACK_DEPTH];

    logic          w_full;
    logic          w_empty;
    logic          w_both;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic          w_err_new;
    logic [PW-1:0] w_sp_dec;
    logic [3:0]    w_alu_flags;
    logic [3:0]    w_next_flags;
    logic          w_take;

    assign w_full    = (r_sp == FULL_CNT);
    assign w_empty   = (r_sp == '0);
    assign w_both    = bus.push && bus.pop;
    assign w_push_ok = bus.push && !bus.pop && !w_full;
    assign w_pop_ok  = bus.pop && !bus.push && !w_empty;
    assign w_err_new = w_both || (bus.push && !bus.pop && w_full)
                              || (bus.pop && !bus.push && w_empty);
    assign w_sp_dec  = r_sp - PW'(1);

    assign w_alu_flags = {bus.alu_result[WIDTH-1], (bus.alu_result == '0),
                          bus.alu_carry, bus.alu_ovf};

    // A successful pop overrides the ALU write; failed/blocked stack ops still let it through.
    always_comb begin
        w_next_flags = r_flags;
        if (w_pop_ok)
            w_next_flags = r_stack[w_sp_dec[IW-1:0]];
        else if (bus.flag_we)
            w_next_flags = (w_alu_flags & bus.flag_mask) | (r_flags & ~bus.flag_mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags  <= 4'b0100;
            r_n_zero <= 1'b0;
            r_err    <= 1'b0;
            r_sp     <= '0;
        end else begin
            r_flags  <= w_next_flags;
            r_n_zero <= ~w_next_flags[2];
            r_err    <= w_err_new || (r_err && !bus.err_clr);
            if (w_push_ok)
                r_sp <= r_sp + PW'(1);
            else if (w_pop_ok)
                r_sp <= w_sp_dec;
        end
    end

    // Entries are not reset; push always saves the pre-update flags.
    always_ff @(posedge clk) begin
        if (!rst && w_push_ok)
            r_stack[r_sp[IW-1:0]] <= r_flags;
    end

    always_comb begin
        w_take = 1'b0;
        case (bus.cond)
            3'b000:  w_take = 1'b1;
            3'b001:  w_take = r_flags[2];
            3'b010:  w_take = ~r_flags[2];
            3'b011:  w_take = r_flags[3] ^ r_flags[0];
            3'b100:  w_take = ~(r_flags[3] ^ r_flags[0]);
            3'b101:  w_take = r_flags[1];
            3'b110:  w_take = ~r_flags[1];
            default: w_take = 1'b0;
        endcase
    end

    assign bus.flags       = r_flags;
    assign bus.n_zero      = r_n_zero;
    assign bus.take        = w_take;
    assign bus.stack_full  = w_full;
    assign bus.stack_empty = w_empty;
    assign bus.stack_err   = r_err;
endmodule
